// File: rtl/morse_key_capture.sv
// Push-button capture for a Morse player: synchronize and debounce key_ni, latch the
// letter on each press and hand exactly one start pulse to the player once it is idle.
module morse_key_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK50_i,
    input  logic       rst_ni,
    input  logic       key_ni,
    input  logic [2:0] SW_i,
    input  logic       busy_i,
    output logic       start_o,
    output logic [2:0] letter_o,
    output logic       pending_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FIRE    = 2'd2
    } state_e;

    logic [1:0]    sync_q;
    logic          key_db_q, key_db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          k_s;
    logic          press;
    logic [2:0]    letter_q;
    state_e        state_q, state_d;
    logic          start_q, start_d;
    logic          pending_q, pending_d;

    assign k_s = sync_q[1];

    always_ff @(posedge CLOCK50_i) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            key_db_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], key_ni};
            key_db_q <= key_db_d;
            cnt_q    <= cnt_d;
        end
    end

    // The edge that completes DEBOUNCE_CYCLES differing samples flips the level itself,
    // so the counter tops out at DEBOUNCE_CYCLES-1 and cannot wrap.
    always_comb begin
        cnt_d    = cnt_q;
        key_db_d = key_db_q;
        if (k_s == key_db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            key_db_d = k_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign press = key_db_q & ~key_db_d;

    always_ff @(posedge CLOCK50_i) begin
        if (!rst_ni) begin
            letter_q <= 3'b000;
        end else if (press) begin
            letter_q <= SW_i;
        end
    end

    always_ff @(posedge CLOCK50_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = busy_i ? PENDING : FIRE;
            PENDING: if (!busy_i) state_d = FIRE;
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they sit in flops alongside state_q.
    always_comb begin
        start_d   = (state_d == FIRE);
        pending_d = (state_d == PENDING);
    end

    assign start_o   = start_q;
    assign pending_o = pending_q;
    assign letter_o  = letter_q;

endmodule

// File: tb/tb_morse_key_capture.sv
// Directed and randomized bench for morse_key_capture with a behavioural model that
// debounces from a sample-history window and tracks the request as wait/fire flags.
module tb_morse_key_capture;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic [2:0] sw;
    logic       busy;
    logic       start_o;
    logic [2:0] letter_o;
    logic       pending_o;

    morse_key_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK50_i(clk),
        .rst_ni   (rst_n),
        .key_ni   (key_n),
        .SW_i     (sw),
        .busy_i   (busy),
        .start_o  (start_o),
        .letter_o (letter_o),
        .pending_o(pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_starts = 0;

    // Reference model state
    bit       m_s1, m_s2;
    bit       m_db;
    bit       hist[$];
    bit [2:0] m_letter;
    bit       m_wait, m_fire;

    task automatic model_edge();
        bit ks;
        bit press;
        bit all_diff;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1;
            hist.delete();
            m_letter = 3'b000; m_wait = 1'b0; m_fire = 1'b0;
            return;
        end
        ks = m_s2;
        press = 1'b0;
        hist.push_back(ks);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_db) all_diff = 1'b0;
            if (all_diff) begin
                press = m_db;
                m_db  = ~m_db;
            end
        end
        m_s2 = m_s1;
        m_s1 = key_n;
        if (press) m_letter = sw;
        if (m_fire) begin
            m_fire = 1'b0;
        end else if (m_wait) begin
            if (!busy) begin
                m_wait = 1'b0;
                m_fire = 1'b1;
            end
        end else if (press) begin
            if (busy) m_wait = 1'b1;
            else      m_fire = 1'b1;
        end
    endtask

    task automatic check_outputs();
        tests++;
        assert (start_o === m_fire) else begin
            fails++;
            $error("FAIL start_o observed=%b expected=%b", start_o, m_fire);
        end
        tests++;
        assert (pending_o === m_wait) else begin
            fails++;
            $error("FAIL pending_o observed=%b expected=%b", pending_o, m_wait);
        end
        tests++;
        assert (letter_o === m_letter) else begin
            fails++;
            $error("FAIL letter_o observed=%h expected=%h", letter_o, m_letter);
        end
        if (start_o === 1'b1) n_starts++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int s0;
        int hold;
        rst_n = 1'b0; key_n = 1'b1; sw = 3'b000; busy = 1'b0;

        // Reset state
        do_reset();
        expect_bit("reset_start", start_o, 1'b0);
        expect_bit("reset_pending", pending_o, 1'b0);
        expect_int("reset_letter", int'(letter_o), 0);
        $display("[TB] reset done");

        // Clean press: start_o high only in the cycle after edge D+1
        s0 = n_starts;
        sw = 3'b101; busy = 1'b0; key_n = 1'b0;
        ticks(D + 1);
        expect_bit("clean_early", start_o, 1'b0);
        tick();
        expect_bit("clean_start", start_o, 1'b1);
        expect_int("clean_letter", int'(letter_o), 5);
        tick();
        expect_bit("clean_start_off", start_o, 1'b0);
        key_n = 1'b1;
        ticks(10);
        expect_int("clean_count", n_starts - s0, 1);
        $display("[TB] clean press: starts=%0d letter=%0d", n_starts - s0, letter_o);

        // Bounce rejection
        s0 = n_starts;
        sw = 3'b011;
        key_n = 1'b0; ticks(3);
        key_n = 1'b1; ticks(1);
        key_n = 1'b0; ticks(2);
        key_n = 1'b1; ticks(12);
        expect_int("bounce_count", n_starts - s0, 0);
        expect_int("bounce_letter", int'(letter_o), 5);
        $display("[TB] bounce: starts=%0d letter=%0d", n_starts - s0, letter_o);

        // Busy deferral
        s0 = n_starts;
        busy = 1'b1; sw = 3'b010; key_n = 1'b0;
        ticks(10);
        expect_bit("defer_pending", pending_o, 1'b1);
        key_n = 1'b1; ticks(10);
        expect_int("defer_nostart", n_starts - s0, 0);
        busy = 1'b0; tick();
        expect_bit("defer_start", start_o, 1'b1);
        expect_bit("defer_pending_off", pending_o, 1'b0);
        expect_int("defer_letter", int'(letter_o), 2);
        ticks(4);
        $display("[TB] busy deferral: starts=%0d letter=%0d", n_starts - s0, letter_o);

        // Latest wins while pending
        s0 = n_starts;
        busy = 1'b1; sw = 3'b011; key_n = 1'b0; ticks(10);
        key_n = 1'b1; ticks(10);
        sw = 3'b111; key_n = 1'b0; ticks(10);
        key_n = 1'b1; sw = 3'b000; ticks(10);
        busy = 1'b0; ticks(5);
        expect_int("latest_count", n_starts - s0, 1);
        expect_int("latest_letter", int'(letter_o), 7);
        $display("[TB] latest wins: starts=%0d letter=%0d", n_starts - s0, letter_o);

        // Reset while pending drops the request
        s0 = n_starts;
        busy = 1'b1; sw = 3'b110; key_n = 1'b0; ticks(10);
        key_n = 1'b1; ticks(10);
        expect_bit("rst_pend_before", pending_o, 1'b1);
        do_reset();
        expect_bit("rst_pend_after", pending_o, 1'b0);
        expect_int("rst_letter", int'(letter_o), 0);
        busy = 1'b0; ticks(12);
        expect_int("rst_nostart", n_starts - s0, 0);
        $display("[TB] reset while pending: starts=%0d", n_starts - s0);

        // Long hold then release
        s0 = n_starts;
        sw = 3'b001; key_n = 1'b0; ticks(20);
        key_n = 1'b1; ticks(20);
        expect_int("hold_count", n_starts - s0, 1);
        $display("[TB] hold/release: starts=%0d", n_starts - s0);

        // Randomized traffic against the model
        for (int seg = 0; seg < 400; seg++) begin
            key_n = ~key_n;
            hold = int'($urandom_range(1, 2 * D + 2));
            for (int c = 0; c < hold; c++) begin
                sw = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) busy = ~busy;
                rst_n = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        rst_n = 1'b1;
        ticks(20);
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_key_capture.md
MORSE_KEY_CAPTURE -- requirements
Module: morse_key_capture

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), the number of consecutive stable cycles needed to accept a key level change; legal range >= 1.
REQ-002 The block SHALL have these ports, one clock, with reset synchronous and active-low:
- CLOCK50_i  input  1  system clock, 50 MHz, rising edge
- rst_ni  input  1  synchronous active-low reset
- key_ni  input  1  raw push button, active-low, asynchronous to CLOCK50_i, bouncy
- SW_i  input  3  letter select from the switches
- busy_i  input  1  downstream Morse FSM is playing a letter
- start_o  output  1  one-cycle request pulse to the FSM
- letter_o  output  3  latched letter select, feeds the letter decoder
- pending_o  output  1  a press was captured and is waiting for busy_i to drop

Function
REQ-003 key_ni SHALL pass through a 2-flop synchronizer before any use; k_s denotes the second flop.
REQ-004 The debounced level key_db SHALL update to k_s only after k_s differs from key_db on DEBOUNCE_CYCLES consecutive clock edges.
REQ-005 Any edge on which k_s equals key_db SHALL clear the debounce counter. Glitches shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-006 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits. The counter SHALL saturate and never wrap.
REQ-007 A press event SHALL occur on the edge where key_db changes 1->0. A release (0->1) SHALL cause no action.
REQ-008 On a press event, SW_i SHALL be latched into letter_o on that same edge. letter_o SHALL hold until the next press event.
REQ-009 The state machine SHALL have states IDLE, PENDING and FIRE.
REQ-010 From IDLE:
- press with busy_i=0 -> FIRE
- press with busy_i=1 -> PENDING
- otherwise stay in IDLE.
REQ-011 From PENDING: busy_i=0 -> FIRE; otherwise stay in PENDING. A press while in PENDING SHALL overwrite letter_o (latest wins) and SHALL NOT create a second request.
REQ-012 If a press and busy_i=0 coincide in PENDING, letter_o SHALL take the new SW_i and the state SHALL go to FIRE, issuing exactly one start_o.
REQ-013 FIRE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-014 Outputs SHALL be registered and decoded from state:
- start_o=1 only in FIRE
- pending_o=1 only in PENDING.
REQ-015 Latency: counting the first edge that samples key_ni low as edge 0, with key_ni held low and busy_i=0, start_o SHALL be high in the cycle after edge DEBOUNCE_CYCLES+1.
REQ-016 start_o SHALL never be high on two consecutive cycles. Each accepted press SHALL yield at most one start_o.

Reset
REQ-017 When rst_ni=0 at a rising edge, the block SHALL set:
- synchronizer flops = 1, key_db = 1, debounce counter = 0
- state = IDLE, start_o = 0, pending_o = 0, letter_o = 3'b000.
REQ-018 Reset asserted in any state, including PENDING or FIRE, SHALL drop the outstanding request with no start_o afterwards. A key held low through reset release SHALL be treated as a new press after debouncing.
REQ-019 Reset SHALL take priority over every other input on the same edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-020 Clean press: SW_i=3'b101, busy_i=0, key_ni driven low at edge 0 and held -> start_o=1 for exactly one cycle after edge 5, letter_o=3'b101, pending_o stays 0.
REQ-021 Bounce rejection: key_ni toggles low 3 cycles, high 1, low 2, high -> no start_o, letter_o unchanged, key_db stays 1.
REQ-022 Busy deferral: busy_i=1, press with SW_i=3'b010 -> pending_o=1, no start_o; busy_i drops at edge N -> start_o=1 in the cycle after edge N, pending_o=0, letter_o=3'b010.
REQ-023 Latest wins: while PENDING, a second press with SW_i=3'b111, then busy_i drops -> a single start_o with letter_o=3'b111.
REQ-024 Reset mid-operation: rst_ni=0 for one edge while PENDING -> pending_o=0, letter_o=0, state IDLE; busy_i then drops -> no start_o.
REQ-025 Release and hold: key held low for 20 cycles then released -> exactly one start_o; no event on release.
